// File: rtl/stream_cipher_pkg.sv
// Shared types and helpers for the stream cipher arbiter slice.
package stream_cipher_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } burst_state_t;

    // Channel-ID width, never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sbox_out = SBOX[sbox_in];

endmodule

// File: rtl/stream_rr_arbiter.sv
// One-hot round-robin arbiter with pointer register.
// Define STREAM_ARB_BURST_EN to let a channel keep the grant for up to MAX_BURST data beats.
module stream_rr_arbiter
    import stream_cipher_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_valid,
`ifdef STREAM_ARB_BURST_EN
    input  logic [NUM_CH-1:0] req_new_msg,
`endif
    output logic [NUM_CH-1:0] grant_c,
    output logic [CH_W-1:0]   grant_idx_c,
    output logic              grant_any_c
);

    if (NUM_CH < 2 || NUM_CH > 8 || MAX_BURST < 1) begin : g_bad_cfg
        $error("stream_rr_arbiter: NUM_CH must be 2..8 and MAX_BURST at least 1");
    end

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] base_c;
    logic [CH_W-1:0] hold_ch_c;
    logic            hold_c;
    int unsigned     cand;

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
        return (32'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
    endfunction

`ifdef STREAM_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    burst_state_t     state;
    logic [CH_W-1:0]  locked_ch;
    logic [CNT_W-1:0] burst_cnt;

    // Locked channel keeps the grant only for back-to-back data beats under the cap.
    assign hold_c = (state == LOCKED) && req_valid[locked_ch] && !req_new_msg[locked_ch]
                    && (32'(burst_cnt) < MAX_BURST);
    assign hold_ch_c = locked_ch;
    assign base_c    = (state == LOCKED) ? wrap_inc(locked_ch) : rr_ptr;
`else
    assign hold_c    = 1'b0;
    assign hold_ch_c = '0;
    assign base_c    = rr_ptr;
`endif

    // First valid channel at or after base_c, wrapping.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = (32'(base_c) + k) % NUM_CH;
            if (!grant_any_c && req_valid[CH_W'(cand)]) begin
                grant_any_c = 1'b1;
                grant_idx_c = CH_W'(cand);
            end
        end
        if (hold_c) begin
            grant_any_c = 1'b1;
            grant_idx_c = hold_ch_c;
        end
        if (grant_any_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
`ifdef STREAM_ARB_BURST_EN
            state     <= IDLE;
            locked_ch <= '0;
            burst_cnt <= '0;
`endif
        end else begin
`ifdef STREAM_ARB_BURST_EN
            if (hold_c) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                // Leaving (or staying out of) a burst; pointer moves past the old owner.
                if (state == LOCKED) begin
                    rr_ptr <= wrap_inc(locked_ch);
                end
                state     <= IDLE;
                burst_cnt <= '0;
                if (grant_any_c) begin
                    if (!req_new_msg[grant_idx_c]) begin
                        state     <= LOCKED;
                        locked_ch <= grant_idx_c;
                        burst_cnt <= CNT_W'(1);
                    end else begin
                        rr_ptr <= wrap_inc(grant_idx_c);
                    end
                end
            end
`else
            if (grant_any_c) begin
                rr_ptr <= wrap_inc(grant_idx_c);
            end
`endif
        end
    end

endmodule

// File: rtl/stream_cipher_arbiter.sv
// Shares one AES S-box keystream between NUM_CH requesters with per-channel index contexts.
// Define STREAM_ARB_BURST_EN to enable burst locking in the arbiter (MAX_BURST data beats).
module stream_cipher_arbiter
    import stream_cipher_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_new_msg,
    input  logic [NUM_CH*BYTE_W-1:0] req_key,
    input  logic [NUM_CH*BYTE_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output byte_t                    out_data
);

    byte_t [NUM_CH-1:0] index_q;
    byte_t [NUM_CH-1:0] key_arr;
    byte_t [NUM_CH-1:0] data_arr;
    logic  [NUM_CH-1:0] grant_c;
    logic  [CH_W-1:0]   grant_idx_c;
    logic               grant_any_c;
    byte_t              sbox_out_c;

    assign key_arr   = req_key;
    assign data_arr  = req_data;
    assign req_ready = grant_c;

    stream_rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
`ifdef STREAM_ARB_BURST_EN
        .req_new_msg (req_new_msg),
`endif
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_any_c (grant_any_c)
    );

    aes_sbox u_sbox (
        .sbox_in  (index_q[grant_idx_c]),
        .sbox_out (sbox_out_c)
    );

    // Granted beat either reloads the channel index or emits one ciphered byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (grant_any_c) begin
                if (req_new_msg[grant_idx_c]) begin
                    index_q[grant_idx_c] <= key_arr[grant_idx_c];
                end else begin
                    index_q[grant_idx_c] <= index_q[grant_idx_c] + 8'd1;
                    out_data             <= data_arr[grant_idx_c] ^ sbox_out_c;
                    out_ch               <= grant_idx_c;
                    out_valid            <= 1'b1;
                end
            end
        end
    end

endmodule
